// File: rtl/mem_master.sv
// mem_master: single-client memory bus master.
// Accepts a read or write request of 1..4 beats at consecutive (wrapping)
// addresses and drives the memory strobes for each beat. Each beat holds its
// strobe for at least ISSUE+WAIT and waits up to TIMEOUT WAIT cycles for
// rdyMem. A timeout aborts the remaining beats and raises err.
// Strobes, busy, done and wAck are decoded from the state register.
module mem_master #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  len,
   input  logic [7:0]  addr,
   input  logic [15:0] wdata,
   output logic        wAck,
   output logic [15:0] rdata,
   output logic        rValid,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        readMem,
   output logic        writeMem,
   output logic [7:0]  addrBus,
   output logic [15:0] memWData,
   input  logic [15:0] memRData,
   input  logic        rdyMem
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Last WAIT count value; reaching it without rdyMem ends the beat in error,
   // so WAIT lasts at most TIMEOUT cycles per beat.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;
   logic        r_wr;
   logic [1:0]  r_left;
   logic [7:0]  r_addr;
   logic [7:0]  r_cnt;
   logic        r_err;
   logic [15:0] r_wdata;
   logic [15:0] r_rdata;
   logic        r_rvalid;

   logic        w_accept;
   logic        w_beat_ok;
   logic        w_tmo;
   logic        w_last;
   logic        w_strobe;
   logic        w_load_wdata;

   // Wrapping address step for the next beat of a burst.
   function automatic logic [7:0] next_addr(input logic [7:0] a);
      return a + 8'd1;
   endfunction

   // Per-cycle event decode shared by the FSM and the datapath.
   always_comb begin
      w_accept     = (r_state == S_IDLE) && req;
      w_beat_ok    = (r_state == S_WAIT) && rdyMem;
      w_tmo        = (r_state == S_WAIT) && !rdyMem && (r_cnt == TMO_LAST);
      w_last       = (r_left == 2'd0);
      w_strobe     = (r_state == S_ISSUE) || (r_state == S_WAIT);
      w_load_wdata = (w_accept && wr) || ((r_state == S_GAP) && r_wr);
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (req) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (rdyMem)     w_state_nxt = w_last ? S_DONE : S_GAP;
            else if (w_tmo) w_state_nxt = S_DONE;
         end
         S_GAP:   w_state_nxt = S_ISSUE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Transaction context: direction, beats left, current address, error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr   <= 1'b0;
         r_left <= 2'd0;
         r_addr <= 8'h00;
         r_err  <= 1'b0;
      end else if (w_accept) begin
         r_wr   <= wr;
         r_left <= len;
         r_addr <= addr;
         r_err  <= 1'b0;
      end else if (w_beat_ok && !w_last) begin
         r_left <= r_left - 2'd1;
         r_addr <= next_addr(r_addr);
      end else if (w_tmo) begin
         r_err  <= 1'b1;
      end
   end

   // WAIT-cycle counter: cleared in ISSUE, advanced on each unready WAIT cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    r_cnt <= 8'h00;
      else if (r_state == S_ISSUE)                 r_cnt <= 8'h00;
      else if ((r_state == S_WAIT) && !rdyMem && !w_tmo) r_cnt <= r_cnt + 8'd1;
   end

   // Write data is captured on the edge entering ISSUE and held through WAIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              r_wdata <= 16'h0000;
      else if (w_load_wdata) r_wdata <= wdata;
   end

   // Read beat capture; rValid marks the cycle after the accepted beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata  <= 16'h0000;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_beat_ok && !r_wr;
         if (w_beat_ok && !r_wr) r_rdata <= memRData;
      end
   end

   assign readMem  = w_strobe && !r_wr;
   assign writeMem = w_strobe && r_wr;
   assign wAck     = (r_state == S_ISSUE) && r_wr;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign err      = r_err;
   assign addrBus  = r_addr;
   assign memWData = r_wdata;
   assign rdata    = r_rdata;
   assign rValid   = r_rvalid;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed bench for mem_master with hand-computed expectations.
module tb_mem_master;

   logic        clk;
   logic        rst;
   logic        req;
   logic        wr;
   logic [1:0]  len;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic        wAck;
   logic [15:0] rdata;
   logic        rValid;
   logic        busy;
   logic        done;
   logic        err;
   logic        readMem;
   logic        writeMem;
   logic [7:0]  addrBus;
   logic [15:0] memWData;
   logic [15:0] memRData;
   logic        rdyMem;

   int n_run  = 0;
   int n_fail = 0;

   // Cycle counters sampled mid-cycle on the falling edge.
   int n_wr_hi  = 0;
   int n_rd_hi  = 0;
   int n_wack   = 0;
   int n_rvalid = 0;
   int n_done   = 0;
   int n_both   = 0;

   logic [7:0]  exp_addr [4];
   logic [15:0] exp_rd   [4];

   mem_master #(.TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .len(len), .addr(addr),
      .wdata(wdata), .wAck(wAck), .rdata(rdata), .rValid(rValid),
      .busy(busy), .done(done), .err(err), .readMem(readMem),
      .writeMem(writeMem), .addrBus(addrBus), .memWData(memWData),
      .memRData(memRData), .rdyMem(rdyMem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (writeMem)            n_wr_hi  <= n_wr_hi + 1;
      if (readMem)             n_rd_hi  <= n_rd_hi + 1;
      if (wAck)                n_wack   <= n_wack + 1;
      if (rValid)              n_rvalid <= n_rvalid + 1;
      if (done)                n_done   <= n_done + 1;
      if (readMem && writeMem) n_both   <= n_both + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int s_wr, s_rd, s_wack, s_rv, s_done;

   task automatic snap();
      s_wr = n_wr_hi; s_rd = n_rd_hi; s_wack = n_wack; s_rv = n_rvalid; s_done = n_done;
   endtask

   initial begin
      exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      exp_rd   = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};

      rst = 1'b0; req = 1'b0; wr = 1'b0; len = 2'd0; addr = 8'h00;
      wdata = 16'h0000; memRData = 16'h0000; rdyMem = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",     32'(busy), 0);
      check("rst_readMem",  32'(readMem), 0);
      check("rst_writeMem", 32'(writeMem), 0);
      check("rst_addrBus",  32'(addrBus), 0);
      check("rst_rdata",    32'(rdata), 0);
      check("rst_memWData", 32'(memWData), 0);
      check("rst_err",      32'(err), 0);
      check("rst_done",     32'(done), 0);
      rst = 1'b1;

      // Single write, ready immediately
      snap();
      req = 1'b1; wr = 1'b1; len = 2'd0; addr = 8'h10; wdata = 16'hA5A5; rdyMem = 1'b1;
      step();
      req = 1'b0; wdata = 16'h0000;
      check("w1_issue_writeMem", 32'(writeMem), 1);
      check("w1_issue_readMem",  32'(readMem), 0);
      check("w1_issue_addrBus",  32'(addrBus), 32'h10);
      check("w1_issue_memWData", 32'(memWData), 32'hA5A5);
      check("w1_issue_wAck",     32'(wAck), 1);
      check("w1_issue_busy",     32'(busy), 1);
      step();
      check("w1_wait_writeMem",  32'(writeMem), 1);
      check("w1_wait_wAck",      32'(wAck), 0);
      check("w1_wait_memWData",  32'(memWData), 32'hA5A5);
      check("w1_wait_done",      32'(done), 0);
      step();
      check("w1_done",           32'(done), 1);
      check("w1_done_writeMem",  32'(writeMem), 0);
      check("w1_done_err",       32'(err), 0);
      step();
      check("w1_idle_busy",      32'(busy), 0);
      check("w1_idle_done",      32'(done), 0);
      check("w1_wr_cycles",      32'(n_wr_hi - s_wr), 2);
      check("w1_wack_pulses",    32'(n_wack - s_wack), 1);
      check("w1_done_pulses",    32'(n_done - s_done), 1);

      // Single read
      snap();
      req = 1'b1; wr = 1'b0; len = 2'd0; addr = 8'h20; memRData = 16'h1234; rdyMem = 1'b1;
      step();
      req = 1'b0;
      check("r1_issue_readMem",  32'(readMem), 1);
      check("r1_issue_addrBus",  32'(addrBus), 32'h20);
      check("r1_issue_wAck",     32'(wAck), 0);
      step();
      check("r1_wait_readMem",   32'(readMem), 1);
      check("r1_wait_rValid",    32'(rValid), 0);
      step();
      check("r1_done",           32'(done), 1);
      check("r1_rValid",         32'(rValid), 1);
      check("r1_rdata",          32'(rdata), 32'h1234);
      check("r1_done_readMem",   32'(readMem), 0);
      step();
      check("r1_idle_rValid",    32'(rValid), 0);
      check("r1_rd_cycles",      32'(n_rd_hi - s_rd), 2);
      check("r1_rvalid_pulses",  32'(n_rvalid - s_rv), 1);
      check("r1_done_pulses",    32'(n_done - s_done), 1);

      // Four-beat read burst wrapping FE..01, with a stray req mid-burst
      snap();
      req = 1'b1; wr = 1'b0; len = 2'd3; addr = 8'hFE; rdyMem = 1'b1;
      step();
      req = 1'b0;
      for (int b = 0; b < 4; b++) begin
         check("b_issue_addr",    32'(addrBus), 32'(exp_addr[b]));
         check("b_issue_readMem", 32'(readMem), 1);
         if (b == 1) begin req = 1'b1; wr = 1'b1; addr = 8'h55; end
         memRData = exp_rd[b];
         step();
         req = 1'b0; wr = 1'b0;
         check("b_wait_readMem",  32'(readMem), 1);
         check("b_wait_addr",     32'(addrBus), 32'(exp_addr[b]));
         step();
         check("b_rValid",        32'(rValid), 1);
         check("b_rdata",         32'(rdata), 32'(exp_rd[b]));
         check("b_after_readMem", 32'(readMem), 0);
         if (b < 3) begin
            check("b_gap_busy",   32'(busy), 1);
            check("b_gap_done",   32'(done), 0);
            step();
         end else begin
            check("b_done",       32'(done), 1);
         end
      end
      step();
      check("b_idle_busy",        32'(busy), 0);
      step();
      check("b_no_stray_txn",     32'(busy), 0);
      check("b_rvalid_pulses",    32'(n_rvalid - s_rv), 4);
      check("b_done_pulses",      32'(n_done - s_done), 1);
      check("b_rd_cycles",        32'(n_rd_hi - s_rd), 8);
      check("b_wr_cycles",        32'(n_wr_hi - s_wr), 0);

      // Read timeout: rdyMem never asserted
      snap();
      req = 1'b1; wr = 1'b0; len = 2'd0; addr = 8'h30; rdyMem = 1'b0;
      step();
      req = 1'b0;
      check("t_issue_readMem", 32'(readMem), 1);
      for (int j = 1; j <= 15; j++) begin
         step();
         check("t_wait_readMem", 32'(readMem), 1);
         check("t_wait_err",     32'(err), 0);
      end
      step();
      check("t_done",          32'(done), 1);
      check("t_err",           32'(err), 1);
      check("t_done_readMem",  32'(readMem), 0);
      check("t_no_rValid",     32'(rValid), 0);
      step();
      check("t_idle_busy",     32'(busy), 0);
      check("t_idle_err",      32'(err), 1);
      repeat (3) step();
      check("t_err_held",      32'(err), 1);
      check("t_rd_cycles",     32'(n_rd_hi - s_rd), 16);
      check("t_done_pulses",   32'(n_done - s_done), 1);

      // Four-beat write aborted by reset in WAIT of the second beat
      req = 1'b1; wr = 1'b1; len = 2'd3; addr = 8'h40; wdata = 16'h1111; rdyMem = 1'b1;
      step();
      req = 1'b0;
      check("a_err_cleared",   32'(err), 0);
      check("a_issue_wdata",   32'(memWData), 32'h1111);
      check("a_issue_wAck",    32'(wAck), 1);
      step();
      step();
      check("a_gap_writeMem",  32'(writeMem), 0);
      check("a_gap_addr",      32'(addrBus), 32'h41);
      wdata = 16'h2222;
      step();
      check("a_issue2_wdata",  32'(memWData), 32'h2222);
      check("a_issue2_wAck",   32'(wAck), 1);
      rdyMem = 1'b0;
      step();
      check("a_wait2_writeMem", 32'(writeMem), 1);
      check("a_wait2_addr",     32'(addrBus), 32'h41);
      snap();
      #2 rst = 1'b0;
      #1;
      check("a_rst_writeMem",  32'(writeMem), 0);
      check("a_rst_busy",      32'(busy), 0);
      check("a_rst_addrBus",   32'(addrBus), 0);
      check("a_rst_memWData",  32'(memWData), 0);
      step();
      check("a_rst_hold_busy", 32'(busy), 0);
      rst = 1'b1;
      step();
      check("a_no_done",       32'(n_done - s_done), 0);

      // Normal single write after reset release
      req = 1'b1; wr = 1'b1; len = 2'd0; addr = 8'h77; wdata = 16'hBEEF; rdyMem = 1'b1;
      step();
      req = 1'b0;
      check("p_issue_writeMem", 32'(writeMem), 1);
      check("p_issue_addr",     32'(addrBus), 32'h77);
      check("p_issue_wdata",    32'(memWData), 32'hBEEF);
      step();
      check("p_wait_writeMem",  32'(writeMem), 1);
      step();
      check("p_done",           32'(done), 1);
      check("p_err",            32'(err), 0);
      step();
      check("p_idle_busy",      32'(busy), 0);
      check("p_done_pulses",    32'(n_done - s_done), 1);

      check("never_both_strobes", 32'(n_both), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
